bus_arbiter16: RTL and testbench
================================

# bus_arbiter16

Two-requester round-robin arbiter that shares one 16-bit datapath (the `mux16` select path) between requesters A and B. It accepts a valid/ack handshake from each requester and drives the `mux16` select. It presents the granted word downstream with a valid/ready handshake. A configurable burst limit bounds how long one requester can hold the path while the other waits.

## Interface
- `BURST_MAX`, default 4: maximum consecutive accepted beats for one grant holder while the other requester is waiting; legal range 1..255.
- `CNT_W`, default 8: burst counter width; must satisfy 2^CNT_W > BURST_MAX.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `a_req`  input  1  requester A has a valid word; must stay high, with `a_data` stable, until `a_ack`.
- `a_data`  input  16  requester A word.
- `a_ack`  output  1  A's word accepted this cycle.
- `b_req`  input  1  requester B has a valid word (same rules as A).
- `b_data`  input  16  requester B word.
- `b_ack`  output  1  B's word accepted this cycle.
- `sel`  output  1  select to the shared `mux16`; 0 = A, 1 = B.
- `out_data`  output  16  `mux16` output (`a_data` when `sel`=0, `b_data` when `sel`=1).
- `out_valid`  output  1  `out_data` carries a granted word.
- `out_ready`  input  1  downstream accepts `out_data` when high together with `out_valid`.

## Operation
- States: IDLE, GNT_A, GNT_B. Registers: `state`, `cnt` (CNT_W bits), `last` (last requester served; 0 = A, 1 = B).
- `sel` = 1 only in GNT_B; otherwise 0. `out_valid` = (GNT_A & `a_req`) | (GNT_B & `b_req`).
- `a_ack` = GNT_A & `a_req` & `out_ready`; `b_ack` = GNT_B & `b_req` & `out_ready`. A beat is accepted when the relevant ack is high.
- IDLE behaviour:
  - Only one requester is high: go to that requester's grant state.
  - Both are high: grant the requester not equal to `last`.
  - Neither is high: stay in IDLE.
  - On entering a grant state: `cnt` ← 0.
- GNT_x, beat accepted, other requester high, `cnt` = BURST_MAX−1: switch to GNT_other, `cnt` ← 0, `last` ← x.
- GNT_x, beat accepted, otherwise: stay in GNT_x. `cnt` ← `cnt`+1, saturating at BURST_MAX−1.
- GNT_x, `x_req` low (holder finished):
  - Other requester high: go directly to GNT_other, `cnt` ← 0, `last` ← x.
  - Otherwise: go to IDLE, `last` ← x.
- If the other requester is never high, the holder keeps the grant indefinitely; `cnt` stays saturated.
- No data is registered; the block is combinational datapath plus registered control.

## Timing
- Reset (`rst_n` low, asynchronous):
  - State: `state`=IDLE, `cnt`=0, `last`=1, so A wins the first tie.
  - Outputs: `sel`=0, `out_valid`=0, `a_ack`=0, `b_ack`=0, while reset is held.
- Grant latency: a request seen in IDLE at edge N gives `out_valid` in cycle N+1. Earliest ack is in cycle N+1 if `out_ready` is high.
- Switch between requesters costs zero idle cycles: the beat after the last accepted beat of the old holder is the first cycle of the new grant.
- Throughput: one beat per cycle while `out_ready` is high.
- `out_ready` low holds state and `cnt`. `out_data` and `sel` stay stable because requesters must keep their data stable.
- Simultaneous requester drop and other-requester assert in the same cycle: switch directly, no IDLE cycle.
- Reset asserted mid-burst: grant is dropped immediately. A requester left waiting re-arbitrates from IDLE after reset release.

## Structure
- Shared package `hack_bus_pkg`: state encoding (IDLE, GNT_A, GNT_B) and requester IDs (REQ_A=0, REQ_B=1).
- One sub-module: instantiate the existing `mux16` for the data path. `sel` drives its select, and its `a`/`b`/`y` connect to `a_data`/`b_data`/`out_data`.

## Test plan
- **Reset and idle:** hold `rst_n` low with both requests high. Require `sel`=0, `out_valid`=0, acks=0. After release, `a_ack` first: A wins the tie.
- **Single requester:** `a_req`=1, `a_data`=16'hAAAA, `out_ready`=1. Require `out_data`=16'hAAAA and `out_valid`=1 one cycle after `a_req` rises, then `a_ack` every cycle and no switch.
- **Burst limit:** both requesters continuously high, `out_ready`=1, BURST_MAX=4. Require the pattern 4× `a_ack`, then 4× `b_ack`, repeating, with `sel` toggling and no gap cycles.
- **Backpressure:** `out_ready`=0 for 3 cycles mid-burst. Require `out_valid`=1, no acks, stable `out_data`, and an unchanged `cnt`; the burst resumes at the same count.
- **Early drop:** B granted; `b_req` falls after 1 beat while `a_req`=1 with `a_data`=16'h5555. Require `sel`=0 and `out_data`=16'h5555 in the next cycle.
- **Reset mid-operation:** pulse `rst_n` low during GNT_B. Require outputs to clear immediately and re-arbitration from IDLE after release, giving `sel`=0 if both requesters are high.

Source files
------------

// File: rtl/hack_bus_pkg.sv
// Shared definitions for the two-requester bus arbiter: grant states,
// requester IDs and a small helper that maps a requester to its grant state.
`timescale 1ns/1ps
package hack_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    function automatic state_t grant_of(input logic id);
        return (id == REQ_B) ? GNT_B : GNT_A;
    endfunction

endpackage

// File: rtl/mux16.sv
// 16-bit two-way select used as the shared arbiter datapath.
`timescale 1ns/1ps
module mux16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sel,
    output logic [15:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/bus_arbiter16.sv
// Round-robin arbiter sharing one 16-bit path between requesters A and B,
// with a burst limit that bounds how long one holder keeps the path.
`timescale 1ns/1ps
module bus_arbiter16
    import hack_bus_pkg::*;
#(
    parameter int unsigned BURST_MAX = 4,
    parameter int unsigned CNT_W     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_req,
    input  logic [15:0] a_data,
    output logic        a_ack,
    input  logic        b_req,
    input  logic [15:0] b_data,
    output logic        b_ack,
    output logic        sel,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;

    logic holder_id;
    logic holder_req;
    logic other_req;
    logic beat;

    mux16 u_mux16 (
        .a   (a_data),
        .b   (b_data),
        .sel (sel),
        .y   (out_data)
    );

    always_comb begin
        sel       = (state_q == GNT_B);
        a_ack     = (state_q == GNT_A) & a_req & out_ready;
        b_ack     = (state_q == GNT_B) & b_req & out_ready;
        out_valid = ((state_q == GNT_A) & a_req) | ((state_q == GNT_B) & b_req);
        beat      = a_ack | b_ack;
    end

    // Both grant states share one body: view the inputs from the holder's side.
    always_comb begin
        holder_id  = (state_q == GNT_B) ? REQ_B : REQ_A;
        holder_req = (holder_id == REQ_B) ? b_req : a_req;
        other_req  = (holder_id == REQ_B) ? a_req : b_req;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (a_req || b_req) begin
                    cnt_d = '0;
                    if (a_req && b_req) begin
                        state_d = grant_of(~last_q);
                    end else begin
                        state_d = grant_of(b_req);
                    end
                end
            end
            GNT_A, GNT_B: begin
                if (!holder_req) begin
                    last_d = holder_id;
                    if (other_req) begin
                        state_d = grant_of(~holder_id);
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (beat) begin
                    if (other_req && (cnt_q == CNT_LAST)) begin
                        state_d = grant_of(~holder_id);
                        cnt_d   = '0;
                        last_d  = holder_id;
                    end else if (cnt_q != CNT_LAST) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // last resets to B so that A wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= REQ_B;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_bus_arbiter16.sv
// Self-checking bench for bus_arbiter16: per-cycle comparison against a
// beat-counting model plus directed literal checks.
`timescale 1ns/1ps
module tb_bus_arbiter16;

    localparam int BURST = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_req = 1'b0;
    logic [15:0] a_data = 16'h0000;
    logic        a_ack;
    logic        b_req = 1'b0;
    logic [15:0] b_data = 16'h0000;
    logic        b_ack;
    logic        sel;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int total = 0;
    int bad   = 0;

    // Model: 0 = no grant, 1 = A, 2 = B; beats counts accepted beats of this grant.
    int mgrant = 0;
    int mbeats = 0;
    int mlast  = 2;

    bus_arbiter16 #(.BURST_MAX(BURST), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_req     (a_req),
        .a_data    (a_data),
        .a_ack     (a_ack),
        .b_req     (b_req),
        .b_data    (b_data),
        .b_ack     (b_ack),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mgrant <= 0;
            mbeats <= 0;
            mlast  <= 2;
        end else if (mgrant == 0) begin
            if (a_req && b_req) mgrant <= (mlast == 1) ? 2 : 1;
            else if (a_req)     mgrant <= 1;
            else if (b_req)     mgrant <= 2;
            mbeats <= 0;
        end else if (!((mgrant == 1) ? a_req : b_req)) begin
            mlast <= mgrant;
            if ((mgrant == 1) ? b_req : a_req) begin
                mgrant <= 3 - mgrant;
                mbeats <= 0;
            end else begin
                mgrant <= 0;
            end
        end else if (out_ready) begin
            if (((mgrant == 1) ? b_req : a_req) && (mbeats + 1 >= BURST)) begin
                mlast  <= mgrant;
                mgrant <= 3 - mgrant;
                mbeats <= 0;
            end else begin
                mbeats <= mbeats + 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("m_sel",   32'(sel),       32'(mgrant == 2));
        chk("m_valid", 32'(out_valid), 32'((mgrant == 1 && a_req) || (mgrant == 2 && b_req)));
        chk("m_a_ack", 32'(a_ack),     32'(mgrant == 1 && a_req && out_ready));
        chk("m_b_ack", 32'(b_ack),     32'(mgrant == 2 && b_req && out_ready));
        chk("m_data",  32'(out_data),  32'((mgrant == 2) ? b_data : a_data));
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen_sel;
        int found;
        logic [15:0] pat_b;
        logic [15:0] pat_any;
        logic [3:0]  pat4;
        logic        a_at_end;

        // Reset held with both requesters high
        a_req = 1'b1; b_req = 1'b1; a_data = 16'hAAAA; b_data = 16'hBBBB; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_sel",   32'(sel),       32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_acks",  32'(a_ack | b_ack), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("tie_first_a_ack", 32'(a_ack), 32'd1);
        chk("tie_first_b_ack", 32'(b_ack), 32'd0);
        @(posedge clk); #1 a_req = 1'b0; b_req = 1'b0;
        @(posedge clk); #1;

        // Single requester
        a_req = 1'b1; a_data = 16'hAAAA;
        @(negedge clk);
        chk("single_valid_latency", 32'(out_valid), 32'd0);
        @(posedge clk); @(negedge clk);
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_data",  32'(out_data),  32'h0000AAAA);
        n = 0; seen_sel = 0;
        repeat (6) begin
            n += int'(a_ack);
            seen_sel |= int'(sel);
            @(posedge clk); @(negedge clk);
        end
        chk("single_ack_count", 32'(n), 32'd6);
        chk("single_no_switch", 32'(seen_sel), 32'd0);
        @(posedge clk); #1 a_req = 1'b0;
        @(posedge clk); #1;

        // Burst limit: last served was A, so B wins this tie
        a_req = 1'b1; b_req = 1'b1;
        @(posedge clk);
        pat_b = '0; pat_any = '0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            pat_b[i]   = b_ack;
            pat_any[i] = a_ack | b_ack;
            @(posedge clk);
        end
        chk("burst_pattern", 32'(pat_b),   32'h00000F0F);
        chk("burst_no_gap",  32'(pat_any), 32'h0000FFFF);

        // Backpressure after one B beat
        @(posedge clk); #1 out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_acks",  32'(a_ack | b_ack), 32'd0);
            chk("bp_data",  32'(out_data), 32'h0000BBBB);
            chk("bp_sel",   32'(sel), 32'd1);
            @(posedge clk);
        end
        #1 out_ready = 1'b1;
        pat4 = '0; a_at_end = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pat4[i] = b_ack;
            if (i == 3) a_at_end = a_ack;
            @(posedge clk);
        end
        chk("bp_resume_count", 32'(pat4), 32'h7);
        chk("bp_then_a",       32'(a_at_end), 32'd1);

        // Early drop of B hands over directly to A
        #1 a_req = 1'b0; b_req = 1'b0;
        @(posedge clk); #1 b_req = 1'b1;
        @(posedge clk); #1 a_req = 1'b1; a_data = 16'h5555;
        @(posedge clk); #1 b_req = 1'b0;
        @(negedge clk);
        chk("drop_sel_before", 32'(sel), 32'd1);
        @(posedge clk); @(negedge clk);
        chk("drop_sel",   32'(sel),       32'd0);
        chk("drop_data",  32'(out_data),  32'h00005555);
        chk("drop_valid", 32'(out_valid), 32'd1);

        // Reset during GNT_B
        @(posedge clk); #1 b_req = 1'b1; b_data = 16'h1234;
        found = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (sel) begin
                found = 1;
                break;
            end
        end
        chk("reach_gnt_b", 32'(found), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sel",   32'(sel),       32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_acks",  32'(a_ack | b_ack), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("post_rst_sel",   32'(sel),   32'd0);
        chk("post_rst_a_ack", 32'(a_ack), 32'd1);
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
